// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: one shared prescaler and period counter feeding CHANNELS duty comparators.
// Period, prescale and duty are double-buffered. Define PWM_BANK_CENTER_EN for center-aligned mode.
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRE_W    = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                SYSCLK,
    input  logic                NSYSRESET,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(2);
    localparam logic [WIDTH-1:0]  EN_MASK       = (WIDTH'(1) << (CHANNELS + 1)) - WIDTH'(1);
`ifdef PWM_BANK_CENTER_EN
    localparam logic [WIDTH-1:0]  CTRL_MASK     = EN_MASK | (WIDTH'(1) << (WIDTH - 1));
`else
    localparam logic [WIDTH-1:0]  CTRL_MASK     = EN_MASK;
`endif

    logic [WIDTH-1:0]    period_q, ctrl_q;
    logic [PRE_W-1:0]    prescale_q;
    logic [WIDTH-1:0]    duty_q [CHANNELS];
    logic [WIDTH-1:0]    period_act_q;
    logic [PRE_W-1:0]    pre_act_q;
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                down_q, down_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                start_q, start_d;
    logic [WIDTH-1:0]    rd_q, rd_d;
    logic                run, center, tick, reload;

    assign run = ctrl_q[0];
`ifdef PWM_BANK_CENTER_EN
    assign center = ctrl_q[WIDTH-1];
`else
    assign center = 1'b0;
`endif
    assign tick = (pre_cnt_q == pre_act_q);

    // Shadows reload on a period boundary, and continuously while stopped.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        down_d    = down_q;
        reload    = 1'b0;
        if (!run) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            down_d    = 1'b0;
            reload    = 1'b1;
        end else if (!tick) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end else begin
            pre_cnt_d = '0;
            if (center && period_act_q != '0) begin
                if (down_q || cnt_q == period_act_q) begin
                    cnt_d  = cnt_q - 1'b1;
                    down_d = (cnt_q != WIDTH'(1));
                    reload = (cnt_q == WIDTH'(1));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                down_d = 1'b0;
                if (cnt_q >= period_act_q) begin
                    cnt_d  = '0;
                    reload = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = run && ctrl_q[i+1] && (cnt_q < duty_act_q[i]);
        end
        // First counter cycle of a period; registered so it lines up with the first pwm cycle.
        start_d = run && (pre_cnt_q == '0) && (cnt_q == '0);
        rd_d = '0;
        if (rd_addr == ADDR_PERIOD)   rd_d = period_q;
        if (rd_addr == ADDR_PRESCALE) rd_d = WIDTH'(prescale_q);
        if (rd_addr == ADDR_CTRL)     rd_d = ctrl_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_addr == ADDR_W'(3 + i)) rd_d = duty_q[i];
        end
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            period_q     <= '1;
            prescale_q   <= '0;
            ctrl_q       <= '0;
            period_act_q <= '1;
            pre_act_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            down_q    <= 1'b0;
            pwm_q     <= '0;
            start_q   <= 1'b0;
            rd_q      <= '0;
        end else begin
            if (wr_en && wr_addr == ADDR_PERIOD)   period_q   <= wr_data;
            if (wr_en && wr_addr == ADDR_PRESCALE) prescale_q <= wr_data[PRE_W-1:0];
            if (wr_en && wr_addr == ADDR_CTRL)     ctrl_q     <= wr_data & CTRL_MASK;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && wr_addr == ADDR_W'(3 + i)) duty_q[i] <= wr_data;
            end
            if (reload) begin
                period_act_q <= period_q;
                pre_act_q    <= prescale_q;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act_q[i] <= duty_q[i];
                end
            end
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            down_q    <= down_d;
            pwm_q     <= pwm_d;
            start_q   <= start_d;
            rd_q      <= rd_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = start_q;
    assign rd_data      = rd_q;

endmodule
